// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement path:
// measurement FSM states and default sizing of the counting window.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COUNT   = 2'd2,
        ST_COMPARE = 2'd3
    } ro_state_e;

    localparam int unsigned WINDOW_CYCLES_DEF = 32'd1024;
    localparam int unsigned SETTLE_CYCLES_DEF = 32'd4;
    localparam int unsigned CNT_W_DEF         = 32'd16;
    localparam int unsigned SYNC_STAGES_DEF   = 32'd2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous RO output, detects its rising edges and
// accumulates them in a saturating counter while counting is enabled.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Count_en,
    input  logic             RO_in,
    output logic [CNT_W-1:0] Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   last_d_r;
    logic                   rise_s;
    logic [CNT_W-1:0]       count_r;

    // Synchronizer chain plus one delayed copy of the last stage for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_r   <= '0;
            last_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], RO_in};
            last_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Rising edge: synchronized level is high now, was low on the previous sample.
    always_comb begin
        rise_s = sync_r[SYNC_STAGES-1] & ~last_d_r;
    end

    // Saturating edge counter; holding at all-ones keeps the comparison monotonic.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_r <= '0;
        end else if (Clear) begin
            count_r <= '0;
        end else if (Count_en && rise_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign Count = count_r;

endmodule

// File: rtl/ro_pair_comparator.sv
// Ring-oscillator pair measurement: enables both ROs, counts their edges over
// a fixed window after a settle time, and reports which oscillator is faster.
module ro_pair_comparator
    import ro_puf_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             RO_a,
    input  logic             RO_b,
    output logic             Enable_a,
    output logic             Enable_b,
    output logic             Busy,
    output logic             Done,
    output logic             Response,
    output logic             Tie,
    output logic [CNT_W-1:0] Count_a,
    output logic [CNT_W-1:0] Count_b
);

    localparam int unsigned      PH_W        = $clog2(max_u(WINDOW_CYCLES, SETTLE_CYCLES)) + 1;
    localparam logic [PH_W-1:0]  PH_ONE      = {{(PH_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW_CYCLES - 1);

    ro_state_e        state_r;
    logic [PH_W-1:0]  phase_cnt_r;
    logic             enable_r;
    logic             busy_r;
    logic             done_r;
    logic             response_r;
    logic             tie_r;
    logic [CNT_W-1:0] count_a_r;
    logic [CNT_W-1:0] count_b_r;
    logic             clear_s;
    logic             count_en_s;
    logic [CNT_W-1:0] live_a_s;
    logic [CNT_W-1:0] live_b_s;

    // Counters clear on the Start-accept edge and only advance inside the window.
    always_comb begin
        clear_s    = (state_r == ST_IDLE) && Start;
        count_en_s = (state_r == ST_COUNT);
    end

    ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
        .Clk(Clk), .Reset(Reset), .Clear(clear_s), .Count_en(count_en_s),
        .RO_in(RO_a), .Count(live_a_s)
    );

    ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
        .Clk(Clk), .Reset(Reset), .Clear(clear_s), .Count_en(count_en_s),
        .RO_in(RO_b), .Count(live_b_s)
    );

    // Measurement FSM with settle/window timer and registered result outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= '0;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            response_r  <= 1'b0;
            tie_r       <= 1'b0;
            count_a_r   <= '0;
            count_b_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r     <= ST_SETTLE;
                        phase_cnt_r <= '0;
                        enable_r    <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (phase_cnt_r == SETTLE_LAST) begin
                        state_r     <= ST_COUNT;
                        phase_cnt_r <= '0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_ONE;
                    end
                end
                ST_COUNT: begin
                    if (phase_cnt_r == WINDOW_LAST) begin
                        state_r     <= ST_COMPARE;
                        phase_cnt_r <= '0;
                        enable_r    <= 1'b0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_ONE;
                    end
                end
                ST_COMPARE: begin
                    // Strict greater-than means a tie always yields Response=0.
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    count_a_r  <= live_a_s;
                    count_b_r  <= live_b_s;
                    response_r <= (live_a_s > live_b_s);
                    tie_r      <= (live_a_s == live_b_s);
                end
                default: begin
                    state_r     <= ST_IDLE;
                    phase_cnt_r <= '0;
                    enable_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign Enable_a = enable_r;
    assign Enable_b = enable_r;
    assign Busy     = busy_r;
    assign Done     = done_r;
    assign Response = response_r;
    assign Tie      = tie_r;
    assign Count_a  = count_a_r;
    assign Count_b  = count_b_r;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Randomized scoreboard bench for ro_pair_comparator: a full-width instance and
// a 4-bit saturating instance share clock, reset, Start and the RO waveforms.
`timescale 1ns/1ps
module tb_ro_pair_comparator;

    localparam int W   = 1000;
    localparam int S   = 4;
    localparam int LAT = S + W + 1;

    typedef struct {
        int n0;
        int pa;
        int pb;
        bit same;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic ro_a_raw = 1'b0, ro_b_raw = 1'b0, same_src = 1'b0;
    logic ro_a, ro_b;
    int   ha = 100, hb = 110;

    logic        en_a, en_b, busy, done, resp, tie;
    logic [15:0] cnt_a, cnt_b;
    logic        en_a4, en_b4, busy4, done4, resp4, tie4;
    logic [3:0]  cnt_a4, cnt_b4;

    int   cyc = 0, n0 = 0, passed = 0, total = 0;
    bit   act = 1'b0;
    exp_t q_main[$], q_sat[$];

    assign ro_a = ro_a_raw;
    assign ro_b = same_src ? ro_a_raw : ro_b_raw;

    ro_pair_comparator #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .RO_a(ro_a), .RO_b(ro_b),
        .Enable_a(en_a), .Enable_b(en_b), .Busy(busy), .Done(done),
        .Response(resp), .Tie(tie), .Count_a(cnt_a), .Count_b(cnt_b)
    );

    ro_pair_comparator #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .Clk(clk), .Reset(reset), .Start(start), .RO_a(ro_a), .RO_b(ro_b),
        .Enable_a(en_a4), .Enable_b(en_b4), .Busy(busy4), .Done(done4),
        .Response(resp4), .Tie(tie4), .Count_a(cnt_a4), .Count_b(cnt_b4)
    );

    initial forever #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Even half-periods plus a 3 ns offset keep RO edges off the clock edges.
    initial begin #3; forever begin #(ha) ro_a_raw = ~ro_a_raw; end end
    initial begin #3; forever begin #(hb) ro_b_raw = ~ro_b_raw; end end

    task automatic chk(input string name, input longint act_v, input longint exp_v);
        total++;
        if (act_v == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
    endtask

    task automatic chk_near(input string name, input int act_v, input real exp_v);
        total++;
        if ($itor(act_v) >= exp_v - 1.0 && $itor(act_v) <= exp_v + 1.0) passed++;
        else $display("FAIL %s: got %0d expected %0f +-1 (cycle %0d)", name, act_v, exp_v, cyc);
    endtask

    // Reference: edges in a window of W clocks = window time / RO period.
    function automatic real exp_count(input int period);
        return (20.0 * W) / $itor(period);
    endfunction

    // Main monitor: per-cycle enable/busy envelope and scoreboard on Done.
    always @(negedge clk) begin
        exp_t e;
        bit   en_exp, busy_exp;
        en_exp   = act && (cyc >= n0) && (cyc < n0 + S + W);
        busy_exp = act && (cyc >= n0) && (cyc <= n0 + S + W);
        chk("enable_a", en_a, en_exp);
        chk("enable_b", en_b, en_exp);
        chk("busy", busy, busy_exp);
        if (done) begin
            if (q_main.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q_main.pop_front();
                chk("latency", cyc - e.n0, LAT);
                chk_near("count_a", int'(cnt_a), exp_count(e.pa));
                chk_near("count_b", int'(cnt_b), exp_count(e.same ? e.pa : e.pb));
                chk("tie", tie, e.same ? 1 : 0);
                chk("response", resp, (!e.same && e.pa < e.pb) ? 1 : 0);
            end
        end
    end

    // Saturating-instance monitor: both counts pin at 15 and tie.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q_sat.size() == 0) begin
                chk("sat_unexpected_done", 1, 0);
            end else begin
                e = q_sat.pop_front();
                chk("sat_latency", cyc - e.n0, LAT);
                chk("sat_count_a", cnt_a4, 15);
                chk("sat_count_b", cnt_b4, 15);
                chk("sat_tie", tie4, 1);
                chk("sat_response", resp4, 0);
            end
        end
    end

    task automatic set_ro(input int a, input int b, input bit s);
        ha = a; hb = b; same_src = s;
    endtask

    task automatic push_exp(input int start_edge);
        exp_t e;
        e.n0 = start_edge; e.pa = 2 * ha; e.pb = 2 * hb; e.same = same_src;
        q_main.push_back(e);
        q_sat.push_back(e);
    endtask

    task automatic start_pulse(input bit expect_done);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        n0 = cyc; act = 1'b1;
        if (expect_done) push_exp(cyc);
    endtask

    task automatic wait_done();
        for (int i = 0; i < LAT + 20 && (q_main.size() != 0 || q_sat.size() != 0); i++)
            @(posedge clk);
        if (q_main.size() != 0 || q_sat.size() != 0) begin
            chk("done_timeout", q_main.size() + q_sat.size(), 0);
            q_main.delete();
            q_sat.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int a, b, k;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_count_a", cnt_a, 0);
        chk("reset_count_b", cnt_b, 0);
        chk("reset_response", resp, 0);
        chk("reset_tie", tie, 0);
        chk("reset_done", done, 0);

        set_ro(100, 110, 1'b0); start_pulse(1'b1); wait_done();
        set_ro(110, 100, 1'b0); start_pulse(1'b1); wait_done();
        set_ro(100, 110, 1'b1); start_pulse(1'b1); wait_done();

        // Reset in the middle of COUNT discards the measurement.
        set_ro(100, 110, 1'b0); start_pulse(1'b0);
        repeat (S + 499) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0; act = 1'b0;
        @(negedge clk);
        chk("midreset_count_a", cnt_a, 0);
        chk("midreset_count_b", cnt_b, 0);
        chk("midreset_done", done, 0);
        repeat (LAT + 50) @(posedge clk);
        start_pulse(1'b1); wait_done();

        // Start re-pulsed while busy must be ignored.
        set_ro(110, 100, 1'b0); start_pulse(1'b1);
        repeat (299) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done();
        repeat (50) @(posedge clk);

        // Start held high: back-to-back runs with one IDLE cycle between.
        set_ro(100, 110, 1'b0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2;
        n0 = cyc; act = 1'b1;
        push_exp(cyc);
        push_exp(cyc + LAT + 1);
        repeat (LAT + 1) @(posedge clk);
        #2 n0 = cyc; start = 1'b0;
        wait_done();

        // Randomized RO periods with clearly separated counts.
        for (int it = 0; it < 5; it++) begin
            k = 0;
            do begin
                a = 2 * $urandom_range(20, 100);
                b = 2 * $urandom_range(20, 100);
                k++;
            end while (k < 100 && ((10000.0 / a - 10000.0 / b) < 3.0 && (10000.0 / b - 10000.0 / a) < 3.0));
            set_ro(a, b, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 37)) @(posedge clk);
            start_pulse(1'b1);
            wait_done();
        end

        repeat (20) @(posedge clk);
        chk("queues_drained", q_main.size() + q_sat.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ro_pair_comparator.md
Name: ro_pair_comparator

Overview:
- Measurement end of the ring-oscillator PUF. Drives the Enable inputs of two ring oscillators and counts rising edges of each RO output over a fixed clock-cycle window.
- Compares the two counts and produces one PUF response bit.
- Sits between a pair of RO instances and the challenge/response controller, which selects RO pairs through an external mux.

Parameters:
- WINDOW_CYCLES, 1024: Clk cycles during which RO edges are counted.
- SETTLE_CYCLES, 4: Clk cycles after Enable rises before counting starts.
- CNT_W, 16: width of each edge counter.
- SYNC_STAGES, 2: flip-flop synchronizer depth on each RO input (minimum 2).

Ports:
- Clk, input, 1: single system clock.
- Reset, input, 1: synchronous, active-high reset.
- Start, input, 1: level sampled in IDLE; begins one measurement.
- RO_a, input, 1: asynchronous output of ring oscillator A.
- RO_b, input, 1: asynchronous output of ring oscillator B.
- Enable_a, output, 1: drives Enable of RO A.
- Enable_b, output, 1: drives Enable of RO B.
- Busy, output, 1: high from SETTLE through COMPARE.
- Done, output, 1: one-cycle pulse; Response and counts valid.
- Response, output, 1: 1 if Count_a > Count_b, else 0.
- Tie, output, 1: 1 if Count_a == Count_b.
- Count_a, output, CNT_W: final edge count of A.
- Count_b, output, CNT_W: final edge count of B.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset state: FSM in IDLE. Enable_a, Enable_b, Busy, Done, Response and Tie are 0. Count_a, Count_b and all synchronizer flops are 0.
- Reset mid-measurement takes effect on the next Clk edge: ROs disabled, measurement discarded, no Done pulse.
- FSM states: IDLE, SETTLE, COUNT, COMPARE.
  - IDLE: Start=1 at a Clk edge moves to SETTLE. On that transition, both internal counters clear and Enable_a and Enable_b go high.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles. Edges are synchronized but not counted.
  - COUNT: lasts exactly WINDOW_CYCLES cycles. Each synchronized rising edge of RO_x seen during COUNT increments counter_x by 1.
  - Leaving COUNT: Enable_a and Enable_b drop on the edge that exits COUNT.
  - COMPARE: lasts 1 cycle. Registers Count_a, Count_b, Response and Tie, and asserts Done for exactly the following cycle. Then returns to IDLE.
- Latency: Done is high in the cycle that begins SETTLE_CYCLES+WINDOW_CYCLES+1 edges after the Start-sampling edge.
- Result outputs: Count_a, Count_b, Response and Tie hold their values until the next COMPARE or Reset.
- Start while Busy=1 is ignored. Start held high continuously produces back-to-back measurements with one IDLE cycle between them.
- Edge detection:
  - Each RO input passes through SYNC_STAGES flops.
  - A rising edge is last-stage 1 while the previous-stage sample was 0.
  - At most one increment per counter per Clk cycle.
  - The RO period must exceed 2 Clk periods. Faster ROs alias; this is not detected.
- Edges still in the synchronizer pipeline when COUNT ends are dropped. Both channels are affected equally.
- Counters saturate at 2^CNT_W-1 and never wrap. Two saturated counts give Tie=1 and Response=0.
- Tie rule: Tie=1 forces Response=0.

Decomposition:
- Shared package ro_puf_pkg holds:
  - the state enum (IDLE/SETTLE/COUNT/COMPARE, 2-bit encoding);
  - default values for WINDOW_CYCLES, SETTLE_CYCLES, CNT_W and SYNC_STAGES.
- Sub-module ro_edge_counter, instantiated twice (one per RO):
  - ports: Clk, Reset, Clear, Count_en, RO_in, Count[CNT_W];
  - contains the synchronizer, rising-edge detect and saturating counter.
- The top level holds the FSM, the window/settle counter and the compare logic.

Test Plan:
- Clk period 20. RO_a modeled as a square wave of period 200, RO_b of period 220. WINDOW_CYCLES=1000, pulse Start -> Done after 1005 edges; Count_a=100±1, Count_b=90±1, Response=1, Tie=0.
- Same setup with the RO periods swapped -> Response=0, Tie=0, counts swapped.
- Both ROs driven from the same period-200 source -> Count_a==Count_b==100±1, Tie=1, Response=0.
- CNT_W=4, WINDOW_CYCLES=1000, periods 200 and 220 -> both counts=15 (saturated), Tie=1, Response=0, no wrap to 0.
- Assert Reset for 1 cycle at COUNT cycle 500 -> next cycle Enable_a=Enable_b=0, Busy=0, counts=0, and no Done pulse. A fresh Start then completes normally.
- Pulse Start again at cycle 300 of an active measurement -> ignored. Exactly one Done pulse, 1 cycle wide, at the original latency. Enable_a and Enable_b are high only during SETTLE and COUNT.
